md_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer owning the HI/LO registers for the 5-stage pipeline; sits in E stage beside the ALU.
- Accepts a start pulse plus operation from E-stage control, runs a fixed-latency multiply or divide, and commits results to HI/LO atomically at completion.
- Serves mthi/mtlo/mfhi/mflo.
- Produces the busy flag and the D-stage stall request for mult/div/mt/mf instructions.

---
 rtl/md_pkg.sv | 47 ++++
 rtl/md_arith.sv | 64 ++++++
 rtl/md_sequencer.sv | 125 ++++++++++++
 tb/tb_md_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// the HI/LO result payload and op-class decode helpers.
package md_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9,
        OP_MFHI  = 4'd10,
        OP_MFLO  = 4'd11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_result_t;

    // Ops that occupy the sequencer for a multi-cycle run
    function automatic logic is_md(input logic [OP_W-1:0] op);
        return (op <= OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops whose operands are interpreted as two's complement
    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result generation for mult/div-class ops, computed
// from the operands and the current HI/LO.
module md_arith
    import md_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output md_result_t      result,
    output logic            div_zero
);

    localparam int unsigned DW = 2 * XLEN;

    logic            sgn;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   a_ext;
    logic [DW-1:0]   b_ext;
    logic [DW-1:0]   prod;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    assign sgn      = is_signed_op(op);
    assign acc      = {hi, lo};
    assign div_zero = (src_b == '0);

    // One multiplier serves both signednesses; the low 64 bits are exact
    assign a_ext = {{XLEN{sgn & src_a[XLEN-1]}}, src_a};
    assign b_ext = {{XLEN{sgn & src_b[XLEN-1]}}, src_b};
    assign prod  = a_ext * b_ext;

    // Sign-magnitude divide: truncating quotient, remainder follows the dividend
    assign a_neg = sgn & src_a[XLEN-1];
    assign b_neg = sgn & src_b[XLEN-1];
    assign a_mag = a_neg ? (~src_a + XLEN'(1)) : src_a;
    assign b_mag = div_zero ? XLEN'(1) : (b_neg ? (~src_b + XLEN'(1)) : src_b);
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo   = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
    assign rem   = a_neg ? (~r_mag + XLEN'(1)) : r_mag;

    always_comb begin
        result = md_result_t'(acc);
        case (op)
            OP_MULT, OP_MULTU: result = md_result_t'(prod);
            OP_MADD, OP_MADDU: result = md_result_t'(acc + prod);
            OP_MSUB, OP_MSUBU: result = md_result_t'(acc - prod);
            OP_DIV, OP_DIVU: begin
                result.hi = rem;
                result.lo = quo;
            end
            default: result = md_result_t'(acc);
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: launches fixed-latency
// ops, commits results atomically, serves mt/mf and raises the D-stage stall.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            hl_wr,
    input  logic            md_use_d,
    output logic            busy,
    output logic            stall_req,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            err
);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    md_result_t       sh_q;
    md_result_t       sh_d;
    md_result_t       arith_res;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic             err_q;
    logic             div_zero;
    logic             accept;
    logic             commit;
    logic             mt_wr;
    logic             err_set;

    md_arith u_arith (
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi       (hi_q),
        .lo       (lo_q),
        .result   (arith_res),
        .div_zero (div_zero)
    );

    // A zero divisor leaves HI/LO as they stood at launch
    assign sh_d = (is_div(op) && div_zero) ? md_result_t'({hi_q, lo_q}) : arith_res;

    // Next-state and per-cycle control decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        mt_wr   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && is_md(op)) begin
                    accept  = 1'b1;
                    err_set = hl_wr;
                    state_d = ST_RUN;
                    cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else begin
                    mt_wr = hl_wr;
                end
            end
            ST_RUN: begin
                err_set = start | hl_wr;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                sh_q <= sh_d;
            end
            if (commit) begin
                hi_q <= sh_q.hi;
                lo_q <= sh_q.lo;
            end else if (mt_wr) begin
                if (op == OP_MTHI) begin
                    hi_q <= src_a;
                end
                if (op == OP_MTLO) begin
                    lo_q <= src_a;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign err       = err_q;
    assign stall_req = md_use_d & (start | busy);
    assign rd_data   = (op == OP_MFHI) ? hi_q :
                       (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural HI/LO model.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        hl_wr    = 1'b0;
    logic        md_use_d = 1'b0;
    logic [3:0]  op       = 4'd0;
    logic [31:0] src_a    = 32'd0;
    logic [31:0] src_b    = 32'd0;
    logic        busy;
    logic        stall_req;
    logic        err;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    md_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .hl_wr     (hl_wr),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .rd_data   (rd_data),
        .hi        (hi),
        .lo        (lo),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Architectural result of a mult/div-class op, straight from the op definitions
    function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        int              ia;
        int              ib;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        ia  = a;
        ib  = b;
        sa  = ia;
        sb  = ib;
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = acc;
        case (o)
            4'd0: res = sa * sb;
            4'd1: res = ua * ub;
            4'd2: if (b != 0) begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd3: if (b != 0) begin
                uq  = ua / ub;
                ur  = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            4'd4: res = acc + 64'(sa * sb);
            4'd5: res = acc + 64'(ua * ub);
            4'd6: res = acc - 64'(sa * sb);
            4'd7: res = acc - 64'(ua * ub);
            default: res = acc;
        endcase
        return res;
    endfunction

    // Behavioural model: m_left is the number of busy cycles still to come
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;
    logic        m_err  = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
            m_err  <= 1'b0;
        end else if (m_left > 0) begin
            if (start || hl_wr) m_err <= 1'b1;
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start && op <= 4'd7) begin
            {p_hi, p_lo} <= ref_op(op, src_a, src_b, {m_hi, m_lo});
            m_left       <= (op == 4'd2 || op == 4'd3) ? int'(DIV_N) : int'(MULT_N);
            if (hl_wr) m_err <= 1'b1;
        end else if (hl_wr) begin
            if (op == 4'd8) m_hi <= src_a;
            if (op == 4'd9) m_lo <= src_a;
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", 32'(busy), 32'(m_left > 0));
        chk("cmp_hi", hi, m_hi);
        chk("cmp_lo", lo, m_lo);
        chk("cmp_err", 32'(err), 32'(m_err));
        chk("cmp_stall", 32'(stall_req), 32'(md_use_d & (start | (m_left > 0))));
        chk("cmp_rd_data", rd_data, (op == 4'd10) ? m_hi : (op == 4'd11) ? m_lo : 32'd0);
    end

    task automatic cyc(input logic s, input logic h, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = s;
        hl_wr = h;
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    task automatic quiet();
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        cyc(1'b0, 1'b1, o, v, 32'd0);
        quiet();
    endtask

    // Launch one op and count the busy cycles that follow (bounded)
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nb);
        cyc(1'b1, 1'b0, o, a, b);
        quiet();
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int nb;
        int ns;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, nb);
        chk("mult_busy_cycles", 32'(nb), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
        chk("div_busy_cycles", 32'(nb), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        mt(OP_MTHI, 32'h11);
        mt(OP_MTLO, 32'h22);
        run_op(OP_DIVU, 32'd7, 32'd0, nb);
        chk("divz_busy_cycles", 32'(nb), 32'd10);
        chk("divz_hi", hi, 32'h11);
        chk("divz_lo", lo, 32'h22);

        mt(OP_MTHI, 32'h1);
        mt(OP_MTLO, 32'h0);
        run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd1, nb);
        chk("maddu_hi", hi, 32'h1);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
        run_op(OP_MSUB, 32'd1, 32'd1, nb);
        chk("msub_hi", hi, 32'h1);
        chk("msub_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        // D-stage stall held across a divide, then read back the new LO/HI
        cyc(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7);
        md_use_d = 1'b1;
        @(negedge clk);
        chk("stall_start_cycle", 32'(stall_req), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        ns = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (stall_req) ns++;
        end
        chk("stall_busy_cycles", 32'(ns), 32'd10);
        chk("stall_after", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        md_use_d = 1'b0;
        op       = OP_MFLO;
        @(negedge clk);
        chk("mflo_after_div", rd_data, 32'd14);
        @(posedge clk);
        #1 op = OP_MFHI;
        @(negedge clk);
        chk("mfhi_after_div", rd_data, 32'd2);

        // Second start in busy cycle 3 is dropped and flags err
        cyc(1'b1, 1'b0, OP_MULT, 32'd3, 32'd4);
        fork
            begin
                @(posedge clk);
                #1 start = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1;
                start = 1'b1;
                src_a = 32'd5;
                src_b = 32'd5;
                @(posedge clk);
                #1 start = 1'b0;
            end
            begin
                @(posedge clk);
                nb = 0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (!busy) break;
                    nb++;
                end
            end
        join
        chk("overlap_busy_cycles", 32'(nb), 32'd5);
        chk("overlap_lo", lo, 32'd12);
        chk("overlap_hi", hi, 32'd0);
        chk("overlap_err", 32'(err), 32'd1);

        // Reset in busy cycle 2 aborts without a later commit
        cyc(1'b1, 1'b0, OP_MULT, 32'd3, 32'd4);
        quiet();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rst_no_commit_lo", lo, 32'd0);
        chk("rst_no_commit_busy", 32'(busy), 32'd0);

        // Random traffic: round 0 stays legal, round 1 also collides with busy
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 400; i++) begin
                logic       s;
                logic       h;
                logic [3:0] o;
                o = 4'($urandom_range(0, 11));
                s = ($urandom_range(0, 3) == 0);
                h = ($urandom_range(0, 5) == 0);
                if (r == 0 && (m_left > 0 || s)) h = 1'b0;
                if (r == 0 && m_left > 0) s = 1'b0;
                cyc(s, h, o, pick_operand(), pick_operand());
                md_use_d = 1'($urandom_range(0, 1));
            end
            quiet();
            md_use_d = 1'b0;
            repeat (12) @(posedge clk);
            #1 reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
